// File: rtl/reg_bus_pkg.sv
// Shared encodings and defaults for the register-to-bus controller.
package reg_bus_pkg;

    localparam int unsigned DEF_WIDTH = 18;
    localparam int unsigned DEF_NREG  = 4;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SW_A = 2'd1;
    localparam logic [1:0] ST_SW_B = 2'd2;

    // True when a select index addresses an existing register.
    function automatic logic idx_ok(input int unsigned idx, input int unsigned nreg);
        return idx < nreg;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// NREG x WIDTH register bank: two asynchronous read ports, one synchronous write port.
module reg_bank
    import reg_bus_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREG  = DEF_NREG,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [NREG];

    // Storage update; writes to unimplemented indices are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we && idx_ok(32'(waddr), NREG)) begin
            mem[waddr] <= wdata;
        end
    end

    // Unimplemented indices read back as zero.
    assign rdata_a = idx_ok(32'(raddr_a), NREG) ? mem[raddr_a] : '0;
    assign rdata_b = idx_ok(32'(raddr_b), NREG) ? mem[raddr_b] : '0;

endmodule

// File: rtl/reg_bus_ctrl.sv
// Register-to-bus controller: READ/LOAD/SWAP over a valid/ready command interface.
module reg_bus_ctrl
    import reg_bus_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREG  = DEF_NREG,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    sel_a,
    input  logic [AW-1:0]    sel_b,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] ar_bus,
    output logic             bus_valid,
    output logic             done,
    output logic             err
);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [WIDTH-1:0] bus_d, ar_d;
    logic             bv_d, done_d, err_d;

    logic             we;
    logic [AW-1:0]    waddr, ra, rb;
    logic [WIDTH-1:0] wdata, rd_a, rd_b;
    logic             accept, a_ok, b_ok;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign a_ok      = idx_ok(32'(sel_a), NREG);
    assign b_ok      = idx_ok(32'(sel_b), NREG);

    reg_bank #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (ra),
        .rdata_a (rd_a),
        .raddr_b (rb),
        .rdata_b (rd_b)
    );

    // Next-state, bank access and next output values.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tmp_d   = tmp_q;
        bus_d   = bus;
        ar_d    = ar_bus;
        bv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        waddr   = a_q;
        wdata   = tmp_q;
        ra      = a_q;
        rb      = b_q;

        case (state_q)
            ST_IDLE: begin
                ra = sel_a;
                rb = sel_b;
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_READ: begin
                            // Bank already returns zero for a bad index.
                            bus_d  = rd_a;
                            ar_d   = rd_b;
                            bv_d   = 1'b1;
                            done_d = 1'b1;
                            err_d  = ~(a_ok & b_ok);
                        end
                        OP_LOAD: begin
                            done_d = 1'b1;
                            if (a_ok) begin
                                we    = 1'b1;
                                waddr = sel_a;
                                wdata = wr_data;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (!(a_ok && b_ok)) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else if (sel_a == sel_b) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_SW_A;
                                a_d     = sel_a;
                                b_d     = sel_b;
                                tmp_d   = rd_a;
                                bus_d   = rd_a;
                                ar_d    = rd_a;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SW_A: begin
                we      = 1'b1;
                waddr   = a_q;
                wdata   = rd_b;
                bus_d   = tmp_q;
                state_d = ST_SW_B;
            end
            ST_SW_B: begin
                we      = 1'b1;
                waddr   = b_q;
                wdata   = tmp_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            tmp_q     <= '0;
            bus       <= '0;
            ar_bus    <= '0;
            bus_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tmp_q     <= tmp_d;
            bus       <= bus_d;
            ar_bus    <= ar_d;
            bus_valid <= bv_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Scoreboard bench for reg_bus_ctrl (NREG=4 main instance, NREG=3 for range errors).
module tb_reg_bus_ctrl;

    typedef struct {
        logic        rd;
        logic        er;
        logic [17:0] b;
        logic [17:0] a;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v4, r4, bv4, dn4, er4;
    logic [1:0]  op4, sa4, sb4;
    logic [17:0] wd4, bus4, ar4;

    logic        v3, r3, bv3, dn3, er3;
    logic [1:0]  op3, sa3, sb3;
    logic [17:0] wd3, bus3, ar3;

    exp_t q4[$];
    exp_t q3[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bus_ctrl #(.WIDTH(18), .NREG(4)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(r4), .cmd_op(op4),
        .sel_a(sa4), .sel_b(sb4), .wr_data(wd4), .bus(bus4), .ar_bus(ar4),
        .bus_valid(bv4), .done(dn4), .err(er4)
    );

    reg_bus_ctrl #(.WIDTH(18), .NREG(3)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(r3), .cmd_op(op3),
        .sel_a(sa3), .sel_b(sb3), .wr_data(wd3), .bus(bus3), .ar_bus(ar3),
        .bus_valid(bv3), .done(dn3), .err(er3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Pops the oldest expected response whenever an instance signals done/bus_valid.
    task automatic score(input string nm, input logic dn, input logic bv, input logic er,
                         input logic [17:0] b, input logic [17:0] a, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            chk({nm, ".unexpected_done"}, {30'd0, dn, bv}, 32'd0);
        end else begin
            e = q.pop_front();
            chk({nm, ".done"}, 32'(dn), 32'd1);
            chk({nm, ".bus_valid"}, 32'(bv), 32'(e.rd));
            chk({nm, ".err"}, 32'(er), 32'(e.er));
            if (e.rd) begin
                chk({nm, ".bus"}, 32'(b), 32'(e.b));
                chk({nm, ".ar_bus"}, 32'(a), 32'(e.a));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (dn4 || bv4)) score("dut4", dn4, bv4, er4, bus4, ar4, q4);
    end

    always @(negedge clk) begin
        if (!rst && (dn3 || bv3)) score("dut3", dn3, bv3, er3, bus3, ar3, q3);
    end

    function automatic exp_t mk(input logic rd, input logic er,
                                input logic [17:0] b, input logic [17:0] a);
        exp_t e;
        e.rd = rd; e.er = er; e.b = b; e.a = a;
        return e;
    endfunction

    // Drive a command at a negedge, wait for ready, push expectation, return one cycle later.
    task automatic send(input bit d3, input logic [1:0] op, input int a, input int b,
                        input logic [17:0] d, input bit push, input exp_t e);
        int n = 0;
        if (d3) begin
            v3 = 1'b1; op3 = op; sa3 = 2'(a); sb3 = 2'(b); wd3 = d;
        end else begin
            v4 = 1'b1; op4 = op; sa4 = 2'(a); sb4 = 2'(b); wd4 = d;
        end
        while (!(d3 ? r3 : r4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send.ready_timeout", 32'(n), 32'd0);
        if (push) begin
            if (d3) q3.push_back(e);
            else    q4.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        v4 = 1'b0;
        v3 = 1'b0;
    endtask

    exp_t none;

    initial begin
        none = mk(1'b0, 1'b0, 18'h0, 18'h0);
        v4 = 0; op4 = 0; sa4 = 0; sb4 = 0; wd4 = 0;
        v3 = 0; op3 = 0; sa3 = 0; sb3 = 0; wd3 = 0;
        repeat (3) @(negedge clk);
        chk("rst.bus", 32'(bus4), 32'd0);
        chk("rst.ar_bus", 32'(ar4), 32'd0);
        chk("rst.outs", {29'd0, bv4, dn4, er4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.cmd_ready", 32'(r4), 32'd1);

        // Read of cleared bank
        send(0, 2'b01, 0, 3, 18'h0, 1, mk(1, 0, 18'h0, 18'h0));
        chk("read0.cmd_ready", 32'(r4), 32'd1);
        idle();

        // Back-to-back LOAD, LOAD, READ
        send(0, 2'b10, 1, 0, 18'h2AAAA, 1, none);
        send(0, 2'b10, 2, 0, 18'h15555, 1, none);
        send(0, 2'b01, 1, 2, 18'h0, 1, mk(1, 0, 18'h2AAAA, 18'h15555));
        idle();

        // SWAP 1,2 with a command held during busy cycles
        send(0, 2'b11, 1, 2, 18'h0, 1, none);
        chk("swap.ready_t1", 32'(r4), 32'd0);
        op4 = 2'b10; sa4 = 2'd1; wd4 = 18'h3FFFF; v4 = 1'b1;
        @(negedge clk);
        chk("swap.ready_t2", 32'(r4), 32'd0);
        @(negedge clk);
        chk("swap.ready_t3", 32'(r4), 32'd1);
        chk("swap.done_t3", 32'(dn4), 32'd1);
        idle();
        send(0, 2'b01, 1, 2, 18'h0, 1, mk(1, 0, 18'h15555, 18'h2AAAA));
        idle();

        // SWAP with identical indices completes immediately
        send(0, 2'b11, 2, 2, 18'h0, 1, none);
        chk("swap_same.ready", 32'(r4), 32'd1);
        send(0, 2'b01, 2, 2, 18'h0, 1, mk(1, 0, 18'h2AAAA, 18'h2AAAA));
        idle();

        // Full-width patterns on the edge registers, plus a NOP
        send(0, 2'b10, 0, 0, 18'h3FFFF, 1, none);
        send(0, 2'b10, 3, 0, 18'h00001, 1, none);
        send(0, 2'b00, 3, 0, 18'h12345, 0, none);
        send(0, 2'b01, 3, 0, 18'h0, 1, mk(1, 0, 18'h00001, 18'h3FFFF));
        idle();

        // Reset during SW_B
        send(0, 2'b11, 1, 2, 18'h0, 0, none);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.bus", 32'(bus4), 32'd0);
        chk("abort.ar_bus", 32'(ar4), 32'd0);
        chk("abort.outs", {29'd0, bv4, dn4, er4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.ready", 32'(r4), 32'd1);
        send(0, 2'b01, 1, 2, 18'h0, 1, mk(1, 0, 18'h0, 18'h0));
        idle();

        // Out-of-range indices on the NREG=3 instance
        send(1, 2'b10, 0, 0, 18'h12345, 1, none);
        send(1, 2'b01, 3, 0, 18'h0, 1, mk(1, 1, 18'h0, 18'h12345));
        send(1, 2'b10, 3, 0, 18'h3FFFF, 1, mk(0, 1, 18'h0, 18'h0));
        send(1, 2'b11, 0, 3, 18'h0, 1, mk(0, 1, 18'h0, 18'h0));
        chk("oob_swap.ready", 32'(r3), 32'd1);
        send(1, 2'b01, 0, 1, 18'h0, 1, mk(1, 0, 18'h12345, 18'h0));
        idle();

        for (int i = 0; i < 20 && (q4.size() != 0 || q3.size() != 0); i++) @(negedge clk);
        chk("drain.q4", 32'(q4.size()), 32'd0);
        chk("drain.q3", 32'(q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
